maccum_folded: RTL

//  Folded matrix-vector multiply-accumulate: out[b] = sum_a W[b][a]*S[a] for all SIZE_B outputs.

---
 rtl/maccum_folded_pkg.sv | 33 +++
 rtl/maccum_folded_if.sv | 29 ++
 rtl/maccum_folded_lane.sv | 49 ++++
 rtl/maccum_folded.sv | 125 ++++++++++++
 4 files changed

// File: rtl/maccum_folded_pkg.sv
// Shared types and size helpers for the folded matrix-vector multiply-accumulate.
package maccum_folded_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int calcOw(input int sizeA, input int width);
    return $clog2(sizeA) + width;
  endfunction

  function automatic int calcAw(input int sizeA, input int width);
    return 2 * width + $clog2(sizeA);
  endfunction

  function automatic int calcSteps(input int sizeA, input int lanes);
    return (sizeA + lanes - 1) / lanes;
  endfunction

  // Clamp v into the signed range of an ow-bit number.
  function automatic logic signed [63:0] satClamp(input logic signed [63:0] v, input int ow);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (ow - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/maccum_folded_if.sv
// Weight, activation and result handshakes of maccum_folded.
// Transfer happens on a clock edge where valid && ready; valid never waits on ready.
interface maccum_folded_if #(
  parameter int SIZE_A = 32,
  parameter int SIZE_B = 32,
  parameter int WIDTH  = 4
);
  localparam int OW = maccum_folded_pkg::calcOw(SIZE_A, WIDTH);

  logic                           iValid_AM_W;
  logic                           oReady_AM_W;
  logic [SIZE_B*SIZE_A*WIDTH-1:0] iData_AM_W;
  logic                           iValid_AM_S;
  logic                           oReady_AM_S;
  logic [SIZE_A*WIDTH-1:0]        iData_AM_S;
  logic                           oValid_BM_WS;
  logic                           iReady_BM_WS;
  logic [SIZE_B*OW-1:0]           oData_BM_WS;

  modport master (
    output iValid_AM_W, iData_AM_W, iValid_AM_S, iData_AM_S, iReady_BM_WS,
    input  oReady_AM_W, oReady_AM_S, oValid_BM_WS, oData_BM_WS
  );

  modport slave (
    input  iValid_AM_W, iData_AM_W, iValid_AM_S, iData_AM_S, iReady_BM_WS,
    output oReady_AM_W, oReady_AM_S, oValid_BM_WS, oData_BM_WS
  );
endinterface

// File: rtl/maccum_folded_lane.sv
// One output row: LANES multipliers over a step-selected slice, adder tree, accumulator.
module mac_lane #(
  parameter int SIZE_A = 32,
  parameter int WIDTH  = 4,
  parameter int LANES  = 4,
  parameter int AW     = 13,
  parameter int STEPS  = 8,
  parameter int STEPW  = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     en,
  input  logic [SIZE_A*WIDTH-1:0]  wRow,
  input  logic [SIZE_A*WIDTH-1:0]  sVec,
  input  logic [STEPW-1:0]         step,
  output logic signed [AW-1:0]     accNext
);
  localparam int PADW = STEPS * LANES * WIDTH;

  // Zero padding makes the out-of-range lanes of the last step contribute nothing.
  logic [PADW-1:0]               wPad;
  logic [PADW-1:0]               sPad;
  logic signed [WIDTH-1:0]       wE   [LANES];
  logic signed [WIDTH-1:0]       sE   [LANES];
  logic signed [2*WIDTH-1:0]     prod [LANES];
  logic signed [AW-1:0]          sum;
  logic signed [AW-1:0]          acc;

  assign wPad = PADW'(wRow);
  assign sPad = PADW'(sVec);

  always_comb begin
    sum = '0;
    for (int l = 0; l < LANES; l++) begin
      wE[l]   = wPad[(int'(step) * LANES + l) * WIDTH +: WIDTH];
      sE[l]   = sPad[(int'(step) * LANES + l) * WIDTH +: WIDTH];
      prod[l] = wE[l] * sE[l];
      sum     = sum + AW'(prod[l]);
    end
  end

  assign accNext = acc + sum;

  always_ff @(posedge clk) begin
    if (rst || clear) acc <= '0;
    else if (en)      acc <= accNext;
  end
endmodule

// File: rtl/maccum_folded.sv
// Folded matrix-vector MAC: captures W and S, runs STEPS accumulate cycles, presents all rows at once.
module maccum_folded
  import maccum_folded_pkg::*;
#(
  parameter int SIZE_A   = 32,
  parameter int SIZE_B   = 32,
  parameter int WIDTH    = 4,
  parameter int LANES    = 4,
  parameter int SHIFT    = 3,
  parameter int SATURATE = 0,
  parameter int RESIDENT = 0
) (
  input  logic          iCLK,
  input  logic          iRST,
  maccum_folded_if.slave bus
);
  localparam int OW    = calcOw(SIZE_A, WIDTH);
  localparam int AW    = calcAw(SIZE_A, WIDTH);
  localparam int STEPS = calcSteps(SIZE_A, LANES);
  localparam int STEPW = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int ROWW  = SIZE_A * WIDTH;

  state_t                        state, stateNext;
  logic                          wFull, sFull;
  logic [SIZE_B*ROWW-1:0]        wReg;
  logic [ROWW-1:0]               sReg;
  logic [STEPW-1:0]              step;
  logic [SIZE_B*OW-1:0]          oDataReg;
  logic [SIZE_B*OW-1:0]          oDataNext;
  logic signed [AW-1:0]          accNext [SIZE_B];
  logic                          wXfer, sXfer, outXfer, lastStep;
  logic                          laneClear, laneEn;

  assign wXfer    = bus.iValid_AM_W && bus.oReady_AM_W;
  assign sXfer    = bus.iValid_AM_S && bus.oReady_AM_S;
  assign outXfer  = bus.oValid_BM_WS && bus.iReady_BM_WS;
  assign lastStep = (step == STEPW'(STEPS - 1));

  always_ff @(posedge iCLK) begin
    if (iRST) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if ((wFull || wXfer) && (sFull || sXfer)) stateNext = RUN;
      RUN:  if (lastStep) stateNext = OUT;
      OUT:  if (outXfer) stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Readys are held low during reset so nothing is captured in that cycle.
  always_comb begin
    bus.oReady_AM_W  = !iRST && (state == IDLE) && (!wFull || (RESIDENT != 0));
    bus.oReady_AM_S  = !iRST && (state == IDLE) && !sFull;
    bus.oValid_BM_WS = (state == OUT);
    laneClear        = (state == IDLE);
    laneEn           = (state == RUN);
  end

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      wFull <= 1'b0;
      sFull <= 1'b0;
      wReg  <= '0;
      sReg  <= '0;
    end else begin
      if (wXfer) begin
        wReg  <= bus.iData_AM_W;
        wFull <= 1'b1;
      end
      if (sXfer) begin
        sReg  <= bus.iData_AM_S;
        sFull <= 1'b1;
      end
      if (outXfer) begin
        sFull <= 1'b0;
        if (RESIDENT == 0) wFull <= 1'b0;
      end
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST || state != RUN) step <= '0;
    else                      step <= step + STEPW'(1);
  end

  for (genvar b = 0; b < SIZE_B; b++) begin : gRow
    mac_lane #(
      .SIZE_A(SIZE_A), .WIDTH(WIDTH), .LANES(LANES),
      .AW(AW), .STEPS(STEPS), .STEPW(STEPW)
    ) uLane (
      .clk     (iCLK),
      .rst     (iRST),
      .clear   (laneClear),
      .en      (laneEn),
      .wRow    (wReg[b*ROWW +: ROWW]),
      .sVec    (sReg),
      .step    (step),
      .accNext (accNext[b])
    );
  end

  // The output register samples accNext so the final step's products are included.
  always_comb begin
    logic signed [AW-1:0] shr;
    logic signed [63:0]   clamped;
    oDataNext = '0;
    for (int b = 0; b < SIZE_B; b++) begin
      shr     = accNext[b] >>> SHIFT;
      clamped = satClamp(64'(shr), OW);
      if (SATURATE != 0) oDataNext[b*OW +: OW] = clamped[OW-1:0];
      else               oDataNext[b*OW +: OW] = shr[OW-1:0];
    end
  end

  always_ff @(posedge iCLK) begin
    if (iRST)                          oDataReg <= '0;
    else if (state == RUN && lastStep) oDataReg <= oDataNext;
  end

  assign bus.oData_BM_WS = oDataReg;
endmodule
